// File: rtl/nark_kernel_pkg.sv
// Shared definitions for the NARK kernel datapath.
//   kmac_state_t  : sequencer FSM states
//   KERNEL_DEPTH  : number of kernel memory entries
//   KERNEL_ADDR_W : kernel memory address width
//   TAPS_W        : width of the tap-count request (0..KERNEL_DEPTH)
package nark_kernel_pkg;

  localparam int KERNEL_DEPTH  = 32;
  localparam int KERNEL_ADDR_W = 5;
  localparam int TAPS_W        = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } kmac_state_t;

endpackage

// File: rtl/kernel_mac_unit.sv
// Combinational multiply-accumulate step: acc_o = acc_i + sext(kdata * pix).
//   kdata_i : signed two's-complement kernel word
//   pix_i   : unsigned pixel
//   acc_i   : running sum
//   acc_o   : running sum plus this product, wrapping modulo 2^ACC_SIZE
module kernel_mac_unit #(
  parameter int DATA_SIZE  = 24,
  parameter int PIXEL_SIZE = 8,
  parameter int ACC_SIZE   = 40
) (
  input  logic [DATA_SIZE-1:0]  kdata_i,
  input  logic [PIXEL_SIZE-1:0] pix_i,
  input  logic [ACC_SIZE-1:0]   acc_i,
  output logic [ACC_SIZE-1:0]   acc_o
);

  localparam int PROD_W = DATA_SIZE + PIXEL_SIZE + 1;

  logic signed [PROD_W-1:0] prod;
  logic        [ACC_SIZE-1:0] prod_ext;

  // Zero-extending the pixel by one bit lets a plain signed multiply treat it
  // as unsigned; the result always fits PROD_W bits.
  assign prod     = $signed(kdata_i) * $signed({1'b0, pix_i});
  assign prod_ext = {{(ACC_SIZE-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_o    = acc_i + prod_ext;

endmodule

// File: rtl/kernel_mac_sequencer.sv
// Kernel MAC sequencer: on START walks kernel addresses 0..TAPS-1, pairs each
// kernel word with one pixel from a valid/ready stream and presents the
// accumulated signed sum on a valid/ready result port.
//   CLK, RST          : clock, synchronous active-high reset
//   START, TAPS       : begin a sum of TAPS taps (clamped to 32), IDLE only
//   KMEM_ADDRESS/DATA : combinational kernel memory read port
//   PIX_DATA/VALID/READY : pixel stream (unsigned pixels)
//   RESULT/VALID/READY   : signed convolution sum output
//   BUSY              : high whenever not IDLE
// ACC_SIZE must be at least DATA_SIZE+PIXEL_SIZE+6 so 32 taps cannot overflow.
module kernel_mac_sequencer
  import nark_kernel_pkg::*;
#(
  parameter int DATA_SIZE  = 24,
  parameter int PIXEL_SIZE = 8,
  parameter int ACC_SIZE   = 40
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [TAPS_W-1:0]        TAPS,
  output logic [KERNEL_ADDR_W-1:0] KMEM_ADDRESS,
  input  logic [DATA_SIZE-1:0]     KMEM_DATA,
  input  logic [PIXEL_SIZE-1:0]    PIX_DATA,
  input  logic                     PIX_VALID,
  output logic                     PIX_READY,
  output logic [ACC_SIZE-1:0]      RESULT,
  output logic                     RESULT_VALID,
  input  logic                     RESULT_READY,
  output logic                     BUSY
);

  localparam logic [TAPS_W-1:0] MAX_TAPS = TAPS_W'(KERNEL_DEPTH);

  kmac_state_t              state_q, state_d;
  logic [KERNEL_ADDR_W-1:0] idx_q, idx_d;
  logic [TAPS_W-1:0]        cnt_q, cnt_d;
  logic [ACC_SIZE-1:0]      acc_q, acc_d;
  logic [ACC_SIZE-1:0]      res_q, res_d;

  logic [ACC_SIZE-1:0]      mac_sum;
  logic                     last_tap;
  logic                     pix_fire;

  kernel_mac_unit #(
    .DATA_SIZE (DATA_SIZE),
    .PIXEL_SIZE(PIXEL_SIZE),
    .ACC_SIZE  (ACC_SIZE)
  ) u_mac (
    .kdata_i(KMEM_DATA),
    .pix_i  (PIX_DATA),
    .acc_i  (acc_q),
    .acc_o  (mac_sum)
  );

  assign PIX_READY    = (state_q == RUN);
  assign KMEM_ADDRESS = (state_q == RUN) ? idx_q : '0;
  assign RESULT       = res_q;
  assign RESULT_VALID = (state_q == DONE);
  assign BUSY         = (state_q != IDLE);

  assign pix_fire = PIX_VALID && PIX_READY;
  // cnt_q >= 1 in RUN, so cnt_q-1 never underflows here.
  assign last_tap = ({1'b0, idx_q} == (cnt_q - TAPS_W'(1)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          acc_d = '0;
          idx_d = '0;
          if (TAPS == '0) begin
            // Empty kernel: the sum is zero and is presented immediately.
            res_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = (TAPS > MAX_TAPS) ? MAX_TAPS : TAPS;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (pix_fire) begin
          acc_d = mac_sum;
          if (last_tap) begin
            res_d   = mac_sum;
            state_d = DONE;
          end else begin
            idx_d = idx_q + KERNEL_ADDR_W'(1);
          end
        end
      end
      DONE: begin
        if (RESULT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

endmodule
